scr1_dmem_resp: RTL and testbench

SCR1_DMEM_RESP -- requirements
Module: scr1_dmem_resp

---
 rtl/scr1_dmem_resp_if.sv | 72 +++++++
 rtl/scr1_dmem_resp.sv | 178 +++++++++++++++++
 tb/tb_scr1_dmem_resp.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_dmem_resp_if.sv
// scr1_dmem_resp_if: data-memory request/response bus plus its shared types.
// Ports: pipe (master) drives req/cmd/width/addr/wdata, memory (slave) drives ack/rdata/resp.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef struct packed {
    type_scr1_mem_cmd_e                cmd;
    type_scr1_mem_width_e              width;
    logic [`SCR1_DMEM_AWIDTH-1:0]      addr;
    logic [`SCR1_DMEM_DWIDTH-1:0]      wdata;
  } dmem_req_t;

endpackage

interface scr1_dmem_resp_if;
  import scr1_dmem_pkg::*;

  logic                          dmem_req_i;
  type_scr1_mem_cmd_e            dmem_cmd_i;
  type_scr1_mem_width_e          dmem_width_i;
  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr_i;
  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata_i;
  logic                          dmem_req_ack_o;
  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata_o;
  type_scr1_mem_resp_e           dmem_resp_o;

  modport master (
    output dmem_req_i,
    output dmem_cmd_i,
    output dmem_width_i,
    output dmem_addr_i,
    output dmem_wdata_i,
    input  dmem_req_ack_o,
    input  dmem_rdata_o,
    input  dmem_resp_o
  );

  modport slave (
    input  dmem_req_i,
    input  dmem_cmd_i,
    input  dmem_width_i,
    input  dmem_addr_i,
    input  dmem_wdata_i,
    output dmem_req_ack_o,
    output dmem_rdata_o,
    output dmem_resp_o
  );

endinterface

// File: rtl/scr1_dmem_resp.sv
// scr1_dmem_resp: single-outstanding data memory with fixed wait latency.
// Ports: clk, rst (async, high), dmem (slave bus); macro SCR1_DMEM_MISALIGN_CHK_EN.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module scr1_dmem_resp
  import scr1_dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  scr1_dmem_resp_if.slave   dmem
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int AW = `SCR1_DMEM_AWIDTH;

  if (MEM_WORDS < 2 || (1 << IW) != MEM_WORDS) begin : g_chk_words
    $error("MEM_WORDS must be a power of two >= 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
    $error("WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dmem_req_t  req_q, req_d;

  logic [31:0] mem [MEM_WORDS];

  logic          ack;
  logic          accept;
  logic          range_err;
  logic          align_err;
  logic          width_err;
  logic          err;
  logic [AW-1:0] addr_al;
  logic [IW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic          we;
  logic          in_resp;

  assign ack    = ~rst & (state_q != ST_WAIT);
  assign accept = dmem.dmem_req_i & ack;

  assign in_resp = ~rst & (state_q == ST_RESP);

  // Anything beyond the storage window errors out.
  assign range_err =
    (req_q.addr >> (IW + 2)) != '0;

  always_comb begin
    width_err = 1'b0;
    align_err = 1'b0;
    addr_al   = req_q.addr;
    be        = 4'b0000;
    wdata_rep = req_q.wdata;
    unique case (req_q.width)
      SCR1_MEM_WIDTH_BYTE: begin
        be        = 4'b0001 << req_q.addr[1:0];
        wdata_rep = {4{req_q.wdata[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
`ifdef SCR1_DMEM_MISALIGN_CHK_EN
        align_err = req_q.addr[0];
`endif
        addr_al[0] = 1'b0;
        be        = req_q.addr[1] ? 4'b1100
                                  : 4'b0011;
        wdata_rep = {2{req_q.wdata[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: begin
`ifdef SCR1_DMEM_MISALIGN_CHK_EN
        align_err = |req_q.addr[1:0];
`endif
        addr_al[1:0] = 2'b00;
        be        = 4'b1111;
      end
      default: begin
        width_err = 1'b1;
      end
    endcase
  end

  assign err  = range_err | align_err | width_err;
  assign widx = addr_al[IW+1:2];

  assign we = in_resp & ~err &
              (req_q.cmd == SCR1_MEM_CMD_WR);

  // FSM state and request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          req_d.cmd   = dmem.dmem_cmd_i;
          req_d.width = dmem.dmem_width_i;
          req_d.addr  = dmem.dmem_addr_i;
          req_d.wdata = dmem.dmem_wdata_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Storage is not reset; a write lands on the RESP edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    dmem.dmem_req_ack_o = ack;
    dmem.dmem_resp_o    = SCR1_MEM_RESP_NOTRDY;
    dmem.dmem_rdata_o   = '0;
    if (in_resp) begin
      if (err) begin
        dmem.dmem_resp_o = SCR1_MEM_RESP_RDY_ER;
      end else begin
        dmem.dmem_resp_o = SCR1_MEM_RESP_RDY_OK;
        if (req_q.cmd == SCR1_MEM_CMD_RD) begin
          dmem.dmem_rdata_o = mem[widx];
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmem_resp.sv
// tb_scr1_dmem_resp: random + directed checks of scr1_dmem_resp.
// Two DUTs: u0 with WAIT_CYCLES=1, u1 with WAIT_CYCLES=0.
module tb_scr1_dmem_resp;
  import scr1_dmem_pkg::*;

  localparam int MEMW = 1024;
  localparam int LIM  = MEMW * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  logic                 req_s   [2];
  type_scr1_mem_cmd_e   cmd_s   [2];
  type_scr1_mem_width_e wid_s   [2];
  logic [31:0]          addr_s  [2];
  logic [31:0]          wdat_s  [2];
  logic                 ack_s   [2];
  logic [31:0]          rdat_s  [2];
  type_scr1_mem_resp_e  resp_s  [2];

  scr1_dmem_resp_if b0 ();
  scr1_dmem_resp_if b1 ();

  assign b0.dmem_req_i   = req_s[0];
  assign b0.dmem_cmd_i   = cmd_s[0];
  assign b0.dmem_width_i = wid_s[0];
  assign b0.dmem_addr_i  = addr_s[0];
  assign b0.dmem_wdata_i = wdat_s[0];
  assign ack_s[0]  = b0.dmem_req_ack_o;
  assign rdat_s[0] = b0.dmem_rdata_o;
  assign resp_s[0] = b0.dmem_resp_o;

  assign b1.dmem_req_i   = req_s[1];
  assign b1.dmem_cmd_i   = cmd_s[1];
  assign b1.dmem_width_i = wid_s[1];
  assign b1.dmem_addr_i  = addr_s[1];
  assign b1.dmem_wdata_i = wdat_s[1];
  assign ack_s[1]  = b1.dmem_req_ack_o;
  assign rdat_s[1] = b1.dmem_rdata_o;
  assign resp_s[1] = b1.dmem_resp_o;

  scr1_dmem_resp #(
    .MEM_WORDS   (MEMW),
    .WAIT_CYCLES (1)
  ) u0 (
    .clk  (clk),
    .rst  (rst),
    .dmem (b0)
  );

  scr1_dmem_resp #(
    .MEM_WORDS   (MEMW),
    .WAIT_CYCLES (0)
  ) u1 (
    .clk  (clk),
    .rst  (rst),
    .dmem (b1)
  );

  // Behavioural model: one outstanding request per DUT,
  // response due WAIT+1 cycles after the accept cycle.
  int          wc       [2] = '{1, 0};
  bit          pend     [2];
  int          due      [2];
  int          free_c   [2];
  int          acc_c    [2];
  logic        p_cmd    [2];
  logic [1:0]  p_wid    [2];
  logic [31:0] p_addr   [2];
  logic [31:0] p_dat    [2];
  logic [31:0] mval     [2][16];
  bit   [3:0]  mknown   [2][16];

  int          resp_cnt [2];
  int          run      [2];
  int          maxrun   [2];
  logic [1:0]  last_rs  [2];
  logic [31:0] last_rd  [2];
  int          last_lat [2];

  task automatic chk(input string n, input int k,
                     input logic [31:0] a,
                     input logic [31:0] e,
                     input logic [31:0] m);
    tests++;
    if (((a ^ e) & m) != 32'h0) begin
      errs++;
      $display("FAIL %s[%0d] got %h exp %h",
               n, k, a, e);
    end
  endtask

  task automatic decode(input logic [31:0] a,
                        input logic [1:0] w,
                        output bit er,
                        output int wi,
                        output int off,
                        output int nb);
    er  = (a >= LIM);
    off = int'(a % 4);
    nb  = 4;
    if (w == 2'd0) nb = 1;
    if (w == 2'd1) begin
      nb = 2;
`ifdef SCR1_DMEM_MISALIGN_CHK_EN
      if (off % 2 != 0) er = 1'b1;
`endif
      off = off - (off % 2);
    end
    if (w == 2'd2) begin
`ifdef SCR1_DMEM_MISALIGN_CHK_EN
      if (off != 0) er = 1'b1;
`endif
      off = 0;
    end
    if (w == 2'd3) er = 1'b1;
    wi = int'((a / 4) % 16);
  endtask

  always @(negedge clk) begin
    logic        e_ack;
    logic [1:0]  e_rs;
    logic [31:0] e_rd;
    logic [31:0] msk;
    logic [31:0] t;
    bit          er;
    int          wi, off, nb;
    for (int k = 0; k < 2; k++) begin
      e_ack = 1'b0;
      e_rs  = 2'd0;
      e_rd  = 32'h0;
      msk   = 32'hFFFF_FFFF;
      if (rst) begin
        pend[k]   = 1'b0;
        free_c[k] = 0;
      end else begin
        e_ack = (cyc >= free_c[k]);
        if (pend[k] && due[k] == cyc) begin
          decode(p_addr[k], p_wid[k],
                 er, wi, off, nb);
          if (er) begin
            e_rs = 2'd2;
          end else begin
            e_rs = 2'd1;
            if (p_cmd[k] == 1'b0) begin
              e_rd = mval[k][wi];
              for (int b = 0; b < 4; b++)
                if (!mknown[k][wi][b])
                  msk[8*b +: 8] = 8'h00;
            end else begin
              t = mval[k][wi];
              for (int b = 0; b < nb; b++) begin
                t[8*(off+b) +: 8] =
                  p_dat[k][8*b +: 8];
                mknown[k][wi][off+b] = 1'b1;
              end
              mval[k][wi] = t;
            end
          end
          pend[k] = 1'b0;
        end
      end
      chk("ack", k, 32'(ack_s[k]),
          32'(e_ack), 32'hFFFF_FFFF);
      chk("resp", k, 32'(resp_s[k]),
          32'(e_rs), 32'hFFFF_FFFF);
      chk("rdata", k, rdat_s[k], e_rd, msk);
      if (resp_s[k] != SCR1_MEM_RESP_NOTRDY) begin
        resp_cnt[k]++;
        run[k]++;
        if (run[k] > maxrun[k]) maxrun[k] = run[k];
        last_rs[k]  = resp_s[k];
        last_rd[k]  = rdat_s[k];
        last_lat[k] = cyc - acc_c[k];
      end else begin
        run[k] = 0;
      end
      if (!rst && req_s[k] && e_ack) begin
        pend[k]   = 1'b1;
        p_cmd[k]  = cmd_s[k];
        p_wid[k]  = wid_s[k];
        p_addr[k] = addr_s[k];
        p_dat[k]  = wdat_s[k];
        acc_c[k]  = cyc;
        due[k]    = cyc + wc[k] + 1;
        free_c[k] = due[k];
      end
    end
    cyc++;
  end

  task automatic issue(input int k,
                       input logic c,
                       input logic [1:0] w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit keep);
    int t;
    req_s[k]  = 1'b1;
    cmd_s[k]  = type_scr1_mem_cmd_e'(c);
    wid_s[k]  = type_scr1_mem_width_e'(w);
    addr_s[k] = a;
    wdat_s[k] = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack_s[k] && t < 40);
    if (!ack_s[k]) begin
      tests++;
      errs++;
      $display("FAIL accept_timeout[%0d] got 0 exp 1",
               k);
    end
    @(posedge clk);
    #1;
    if (!keep) req_s[k] = 1'b0;
  endtask

  task automatic idle(input int k);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (pend[k] && t < 40);
    if (pend[k]) begin
      tests++;
      errs++;
      $display("FAIL resp_timeout[%0d] got 0 exp 1",
               k);
    end
  endtask

  task automatic lit(input string n, input int k,
                     input logic [31:0] a,
                     input logic [31:0] e);
    chk(n, k, a, e, 32'hFFFF_FFFF);
  endtask

  task automatic xfer(input int k, input logic c,
                      input logic [1:0] w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    issue(k, c, w, a, d, 1'b0);
    idle(k);
  endtask

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [1:0] BY = 2'd0;
  localparam logic [1:0] HW = 2'd1;
  localparam logic [1:0] WD = 2'd2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] a;
    bit kp;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_s[k]  = 1'b0;
      cmd_s[k]  = SCR1_MEM_CMD_RD;
      wid_s[k]  = SCR1_MEM_WIDTH_WORD;
      addr_s[k] = 32'h0;
      wdat_s[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    lit("rst_ack", 0, 32'(ack_s[0]), 32'h0);
    rst = 1'b0;
    #1;
    lit("post_rst_ack", 0, 32'(ack_s[0]), 32'h1);

    xfer(0, WR, WD, 32'h10, 32'hDEADBEEF);
    lit("wr10_resp", 0, 32'(last_rs[0]), 32'd1);
    lit("wr10_lat", 0, last_lat[0], 32'd2);
    xfer(0, RD, WD, 32'h10, 32'h0);
    lit("rd10_data", 0, last_rd[0], 32'hDEADBEEF);
    lit("rd10_lat", 0, last_lat[0], 32'd2);

    xfer(0, WR, WD, 32'h10, 32'h0);
    xfer(0, WR, BY, 32'h13, 32'hFFFF_FFA5);
    xfer(0, RD, WD, 32'h10, 32'h0);
    lit("byte_rd", 0, last_rd[0], 32'hA500_0000);
    xfer(0, WR, HW, 32'h12, 32'hFFFF_1234);
    xfer(0, RD, WD, 32'h10, 32'h0);
    lit("hw_rd", 0, last_rd[0], 32'h1234_0000);

    xfer(0, RD, WD, 32'h1000, 32'h0);
    lit("oor_resp", 0, 32'(last_rs[0]), 32'd2);
    lit("oor_rdata", 0, last_rd[0], 32'h0);
    xfer(0, RD, WD, 32'h10, 32'h0);
    lit("after_oor", 0, 32'(last_rs[0]), 32'd1);

    xfer(0, WR, WD, 32'h20, 32'h1111_1111);
    xfer(0, WR, WD, 32'h22, 32'hCAFE_F00D);
`ifdef SCR1_DMEM_MISALIGN_CHK_EN
    lit("mis_resp", 0, 32'(last_rs[0]), 32'd2);
    xfer(0, RD, WD, 32'h20, 32'h0);
    lit("mis_rd", 0, last_rd[0], 32'h1111_1111);
`else
    lit("mis_resp", 0, 32'(last_rs[0]), 32'd1);
    xfer(0, RD, WD, 32'h20, 32'h0);
    lit("mis_rd", 0, last_rd[0], 32'hCAFE_F00D);
`endif

    xfer(0, WR, WD, 32'h30, 32'h0102_0304);
    issue(0, WR, WD, 32'h30, 32'h55AA_55AA, 1'b0);
    n0 = resp_cnt[0];
    rst = 1'b1;
    #1;
    lit("mid_rst_ack", 0, 32'(ack_s[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("abort_noresp", 0, resp_cnt[0] - n0, 32'd0);
    xfer(0, RD, WD, 32'h30, 32'h0);
    lit("abort_rd", 0, last_rd[0], 32'h0102_0304);

    for (int i = 0; i < 4; i++)
      xfer(1, WR, WD, 32'(4 * i), 32'(32'hA0 + i));
    n0 = resp_cnt[1];
    maxrun[1] = 0;
    for (int i = 0; i < 4; i++)
      issue(1, RD, WD, 32'(4 * i), 32'h0, i < 3);
    idle(1);
    lit("b2b_cnt", 1, resp_cnt[1] - n0, 32'd4);
    lit("b2b_run", 1, maxrun[1], 32'd4);
    lit("b2b_last", 1, last_rd[1], 32'hA3);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(7) == 0)
          a = 32'(LIM) + 32'($urandom_range(255));
        else
          a = 32'($urandom_range(63));
        kp = 1'($urandom_range(1));
        issue(k, 1'($urandom_range(1)),
              2'($urandom_range(2)), a,
              $urandom(), kp);
        if (!kp) repeat ($urandom_range(2)) begin
          @(posedge clk);
          #1;
        end
      end
      req_s[k] = 1'b0;
      idle(k);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             tests, errs);
    $finish;
  end

endmodule
